// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequences one FFT run per rising edge of the start request.
// Each run captures SAMPLE_NUM ADC samples, pulses fft_start, then waits for
// fft_done. If fft_done does not arrive within TIMEOUT WAIT cycles, the run
// reports a timeout instead. Every completed run ends with a shutdown pulse.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   valid              start request level (a rising edge starts a run)
//   adc_vld            sample strobe, used only while capturing
//   fft_done           FFT completion strobe, used only while waiting
//   capture_en         high while samples are being captured
//   sample_cnt         index of the next sample to capture
//   fft_start          one-cycle FFT start pulse
//   busy               high whenever a run is in progress
//   result_ready       one-cycle pulse when the FFT completes successfully
//   timeout_err        sticky timeout flag, cleared by the next accepted start
//   shutdown           one-cycle end-of-run pulse to the key controller
module fft_seq_ctrl #(
  parameter int SAMPLE_NUM = 1024,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic                          adc_vld,
  input  logic                          fft_done,
  output logic                          capture_en,
  output logic [$clog2(SAMPLE_NUM)-1:0] sample_cnt,
  output logic                          fft_start,
  output logic                          busy,
  output logic                          result_ready,
  output logic                          timeout_err,
  output logic                          shutdown
);
  localparam int CW = $clog2(SAMPLE_NUM);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    r_state;
  logic          r_valid_d;
  logic [CW-1:0] r_sample_cnt;
  logic [TW-1:0] r_timer;
  logic          r_success;
  logic          r_timeout_err;
  logic          w_trig;

  assign w_trig = valid & ~r_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid_d     <= 1'b0;
      r_sample_cnt  <= '0;
      r_timer       <= '0;
      r_success     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // The request level is tracked in every state, so a rising edge seen
      // outside IDLE is consumed rather than queued.
      r_valid_d <= valid;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_sample_cnt  <= '0;
            r_timeout_err <= 1'b0;
            r_state       <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (adc_vld) begin
            if (r_sample_cnt == CW'(SAMPLE_NUM - 1)) begin
              r_sample_cnt <= '0;
              r_state      <= S_START;
            end else begin
              r_sample_cnt <= r_sample_cnt + CW'(1);
            end
          end
        end
        S_START: begin
          r_timer   <= '0;
          r_success <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // fft_done has priority, so a done in the final cycle is a success.
          if (fft_done) begin
            r_success <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registers only.
  assign capture_en   = (r_state == S_CAPTURE);
  assign fft_start    = (r_state == S_START);
  assign busy         = (r_state != S_IDLE);
  assign shutdown     = (r_state == S_DONE);
  assign result_ready = (r_state == S_DONE) & r_success;
  assign timeout_err  = r_timeout_err;
  assign sample_cnt   = r_sample_cnt;
endmodule
